// File: rtl/rr_arbiter_4way.sv
// rr_arbiter_4way
//   Round-robin arbiter that shares one 32-bit datapath among four requesters.
//   It drives the 2-bit select of a downstream mux32_4way and a one-hot grant
//   vector. Once granted, an owner keeps the bus until it drops its request.
//   Ties between simultaneous requesters are broken by a rotating pointer that
//   always sits one position past the most recent winner.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, a hold counter limits how long one owner may keep the bus.
//   After MAX_HOLD cycles of ownership, if another requester is waiting, the
//   grant is taken away and passed on, and timeout pulses for one cycle.
//   When undefined, there is no hold counter and timeout is tied to 0.
//
// Parameters:
//   MAX_HOLD   maximum cycles one owner may hold the grant (2..255)
//   CNT_W      hold counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   req        [3:0] level request per requester, held until done
//   grant      [3:0] registered one-hot grant, zero when idle
//   select     [1:0] registered index of the current or last owner
//   bus_valid  registered OR of grant
//   timeout    one-cycle pulse on a forced release
module rr_arbiter_4way #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       bus_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] select_nxt;
  logic [3:0] others;
  logic [1:0] win;
  logic       win_found;
  logic       force_release;

  // Reject parameter combinations the hold counter cannot represent.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_param_check
    $error("rr_arbiter_4way: illegal MAX_HOLD/CNT_W combination");
  end

  // Rotate the request vector so the pointer position lands at bit 0, take
  // the lowest set bit, then rotate the offset back into an absolute index.
  // The top bit of the result says whether any request was present at all.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    logic       found;
    dbl   = {r, r} >> p;
    rot   = dbl[3:0];
    off   = 2'd0;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) begin
        off   = 2'(i);
        found = 1'b1;
      end
    end
    return {found, 2'(off + p)};
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  // The owner is evicted only when its time is up and someone else is
  // actually waiting; otherwise it keeps the bus with a saturated counter.
  assign force_release = (state == GRANT) && ((req & grant) != 4'b0000) &&
                         (hold_cnt == HOLD_LAST) && win_found;

  // Hold counter: cleared whenever the grant vector changes (new owner or
  // going idle), otherwise counts ownership cycles and saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (grant_nxt != grant) begin
      hold_cnt <= '0;
    end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  // Timeout is a registered copy of the forced-release decision, so it is
  // high exactly in the cycle the new owner's grant first appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= force_release;
    end
  end
`else
  assign force_release = 1'b0;
  assign timeout       = 1'b0;
`endif

  // Next-state logic. Candidates are requesters other than the current
  // owner; in IDLE that is simply every requester. When the owner lets go
  // (or is evicted) and somebody is waiting, the new grant is issued at the
  // same edge so there is no idle bubble between owners.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    grant_nxt  = grant;
    select_nxt = select;
    others     = req & ~grant;
    {win_found, win} = pick(others, ptr);
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nxt  = 4'b0001 << win;
          select_nxt = win;
          ptr_nxt    = win + 2'd1;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (((req & grant) == 4'b0000) || force_release) begin
          if (win_found) begin
            grant_nxt  = 4'b0001 << win;
            select_nxt = win;
            ptr_nxt    = win + 2'd1;
          end else begin
            grant_nxt = 4'b0000;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        grant_nxt = 4'b0000;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers. Reset wins over everything, including an
  // active grant, so the bus is released at the reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      grant     <= 4'b0000;
      select    <= 2'd0;
      bus_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      select    <= select_nxt;
      bus_valid <= |grant_nxt;
    end
  end

endmodule
